// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : MDop encodings and operand helpers for the multiply/divide unit
// Revision    : 1.0
// ============================================================================
package mult_div_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring-division iteration (33-bit partial remainder)
// Revision    : 1.0
// ============================================================================
module div_step (
    input  logic [32:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_divisor,
    output logic [32:0] o_rem,
    output logic [31:0] o_quo
);

    logic [33:0] w_shift;
    logic [33:0] w_diff;

    // Next dividend bit comes from the MSB of the quotient register, while the
    // new quotient bit enters at its LSB.
    assign w_shift = {i_rem, i_quo[31]};
    assign w_diff  = w_shift - {2'b00, i_divisor};
    assign o_rem   = w_diff[33] ? w_shift[32:0] : w_diff[32:0];
    assign o_quo   = {i_quo[30:0], ~w_diff[33]};

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative 32-bit MULT/MULTU/DIV/DIVU/MTHI/MTLO with HI/LO regs
// Revision    : 1.0
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIN  = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_is_div;
    logic        r_sa;
    logic        r_sb;
    logic        r_dz;
    logic [31:0] r_a_orig;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;

    logic        w_signed;
    logic        w_is_div;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod;
    logic [32:0] w_rem_next;
    logic [31:0] w_quo_next;

    assign w_signed   = (MDop == MD_MULT) || (MDop == MD_DIV);
    assign w_is_div   = (MDop == MD_DIV)  || (MDop == MD_DIVU);
    assign w_abs_a    = abs32(A, w_signed);
    assign w_abs_b    = abs32(B, w_signed);
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
    assign w_prod     = (r_sa ^ r_sb) ? (~r_acc + 64'd1) : r_acc;

    div_step u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_dvsr),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dz     <= 1'b0;
            r_a_orig <= 32'd0;
            r_acc    <= 64'd0;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_rem    <= 33'd0;
            r_quo    <= 32'd0;
            r_dvsr   <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        case (MDop)
                            MD_MTHI: r_hi <= A;
                            MD_MTLO: r_lo <= A;
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                r_state  <= c_RUN;
                                r_busy   <= 1'b1;
                                r_cnt    <= 5'd0;
                                r_is_div <= w_is_div;
                                r_sa     <= w_signed & A[31];
                                r_sb     <= w_signed & B[31];
                                r_dz     <= (B == 32'd0);
                                r_a_orig <= A;
                                r_acc    <= 64'd0;
                                r_mcand  <= {32'd0, w_abs_a};
                                r_mplier <= w_abs_b;
                                r_rem    <= 33'd0;
                                r_quo    <= w_abs_a;
                                r_dvsr   <= w_abs_b;
                            end
                            default: ;
                        endcase
                    end
                end
                c_RUN: begin
                    if (r_is_div) begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= {r_mcand[62:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[31:1]};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= c_FIN;
                    end
                end
                c_FIN: begin
                    if (r_is_div) begin
                        // Divide-by-zero reports the raw dividend, so no sign fixup.
                        if (r_dz) begin
                            r_lo <= 32'hFFFF_FFFF;
                            r_hi <= r_a_orig;
                        end else begin
                            r_lo <= (r_sa ^ r_sb) ? (~r_quo + 32'd1) : r_quo;
                            r_hi <= r_sa ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
                        end
                    end else begin
                        r_lo <= w_prod[31:0];
                        r_hi <= w_prod[63:32];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit
// Revision    : 1.0
// ============================================================================
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  MDop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int          total;
    int          bad;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .MDop  (MDop),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one multiply/divide, optionally injecting ignored starts mid-run,
    // then check occupancy, done pulse and HI/LO against hand-computed values.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input bit inject);
        int nb;
        nb = 0;
        @(negedge clk);
        MDop = op; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom; MDop = MD_MTLO;
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            if (nb == 10) begin
                check({tag, " hi_hold"}, HI, m_hi);
                check({tag, " lo_hold"}, LO, m_lo);
            end
            if (inject) begin
                case (nb)
                    5: begin start = 1'b1; MDop = MD_MTHI; A = 32'h0000_DEAD; end
                    8: begin start = 1'b1; MDop = MD_DIV;  A = 32'd9; B = 32'd3; end
                    default: start = 1'b0;
                endcase
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, 32'(nb), 32'd33);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " HI"}, HI, exp_hi);
        check({tag, " LO"}, LO, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
        @(negedge clk);
        check({tag, " done_fall"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int nb;
        int ndone;
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; MDop = MD_MULT; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        do_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        do_op("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        do_op("mult_min",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        do_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_op("divu_7_2",  MD_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0);
        do_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
        do_op("divu_by0",  MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b0);

        // MTLO while idle
        @(negedge clk);
        MDop = MD_MTLO; A = 32'h0000_1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mtlo LO", LO, 32'h0000_1234);
        check("mtlo HI", HI, m_hi);
        check("mtlo busy", {31'd0, busy}, 32'd0);
        check("mtlo done", {31'd0, done}, 32'd0);
        m_lo = 32'h0000_1234;

        do_op("multu_inj", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);

        // Abort a DIVU with reset on its 10th busy cycle
        @(negedge clk);
        MDop = MD_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 10) begin
            nb++;
            if (nb < 10) @(negedge clk);
        end
        check("abort reached", 32'(nb), 32'd10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort HI", HI, 32'd0);
        check("abort LO", LO, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        check("abort no_done", 32'(ndone), 32'd0);

        do_op("multu_3x4", MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
